// File: rtl/uart_tx_rx_pair_if.sv
// ---------------------------------------------------------------------------
// uart_tx_rx_pair_if
// Bundles the parallel/serial signals of the UART pair so the design and its
// user share one port list.
//   tx_data  : word to transmit (user -> UART)
//   tx_rq    : send request, level sampled on the clock (user -> UART)
//   tx_busy  : frame in progress on txd (UART -> user)
//   txd      : serial output, idles high (UART -> line)
//   rxd      : serial input (line -> UART)
//   rx_data  : last good received word (UART -> user)
//   rx_ready : one-cycle pulse, rx_data updated (UART -> user)
//   rx_error : one-cycle pulse, stop bit sampled low (UART -> user)
// Modports: slave = UART side, master = user/line side.
// ---------------------------------------------------------------------------
interface uart_tx_rx_pair_if #(
    parameter int SIZE = 8
);
    logic [SIZE-1:0] tx_data;
    logic            tx_rq;
    logic            tx_busy;
    logic            txd;
    logic            rxd;
    logic [SIZE-1:0] rx_data;
    logic            rx_ready;
    logic            rx_error;

    modport master (
        output tx_data, tx_rq, rxd,
        input  tx_busy, txd, rx_data, rx_ready, rx_error
    );

    modport slave (
        input  tx_data, tx_rq, rxd,
        output tx_busy, txd, rx_data, rx_ready, rx_error
    );
endinterface

// File: rtl/uart_tx_rx_pair.sv
// ---------------------------------------------------------------------------
// uart_tx_rx_pair
// Single-clock UART transmitter and receiver. Frame: start bit (0), SIZE data
// bits LSB first, stop bit (1); every bit lasts CLKS_PER_BIT clocks.
// Ports:
//   i_clk   : system clock, all logic on the rising edge
//   i_reset : asynchronous, active-low reset; aborts any frame in progress
//   bus     : uart_tx_rx_pair_if.slave (tx_data, tx_rq, tx_busy, txd, rxd,
//             rx_data, rx_ready, rx_error)
// rxd is used without a synchroniser: it must come from this clock domain.
// ---------------------------------------------------------------------------
module uart_tx_rx_pair #(
    parameter int SIZE         = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    uart_tx_rx_pair_if.slave      bus
);
    localparam int CW  = $clog2(CLKS_PER_BIT + 1);
    localparam int BW  = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int MID = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CW-1:0] TX_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] RX_BIT   = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] RX_MID   = CW'(MID);
    localparam logic [BW-1:0] LAST_BIT = BW'(SIZE - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_state_t;

    tx_state_t       r_tx_state, w_tx_state;
    logic [CW-1:0]   r_tx_cnt,   w_tx_cnt;
    logic [BW-1:0]   r_tx_bit,   w_tx_bit;
    logic [SIZE-1:0] r_tx_shift, w_tx_shift;
    logic            r_txd,      w_txd;
    logic            r_tx_busy,  w_tx_busy;

    rx_state_t       r_rx_state, w_rx_state;
    logic [CW-1:0]   r_rx_cnt,   w_rx_cnt;
    logic [BW-1:0]   r_rx_bit,   w_rx_bit;
    logic [SIZE-1:0] r_rx_shift, w_rx_shift;
    logic [SIZE-1:0] r_rx_data,  w_rx_data;
    logic            r_rx_ready, w_rx_ready;
    logic            r_rx_error, w_rx_error;

    // TX next state: txd/tx_busy are computed one edge ahead so they come straight from flops.
    always_comb begin
        w_tx_state = r_tx_state;
        w_tx_cnt   = r_tx_cnt;
        w_tx_bit   = r_tx_bit;
        w_tx_shift = r_tx_shift;
        w_txd      = r_txd;
        w_tx_busy  = r_tx_busy;
        case (r_tx_state)
            TX_IDLE: begin
                if (bus.tx_rq) begin
                    w_tx_state = TX_START;
                    w_tx_cnt   = '0;
                    w_tx_bit   = '0;
                    w_tx_shift = bus.tx_data;
                    w_txd      = 1'b0;
                    w_tx_busy  = 1'b1;
                end else begin
                    w_txd      = 1'b1;
                    w_tx_busy  = 1'b0;
                end
            end
            TX_START: begin
                if (r_tx_cnt == TX_LAST) begin
                    w_tx_state = TX_DATA;
                    w_tx_cnt   = '0;
                    w_txd      = r_tx_shift[0];
                    w_tx_shift = r_tx_shift >> 1;
                end else begin
                    w_tx_cnt   = r_tx_cnt + CW'(1);
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == TX_LAST) begin
                    w_tx_cnt = '0;
                    if (r_tx_bit == LAST_BIT) begin
                        w_tx_state = TX_STOP;
                        w_txd      = 1'b1;
                    end else begin
                        w_tx_bit   = r_tx_bit + BW'(1);
                        w_txd      = r_tx_shift[0];
                        w_tx_shift = r_tx_shift >> 1;
                    end
                end else begin
                    w_tx_cnt = r_tx_cnt + CW'(1);
                end
            end
            TX_STOP: begin
                // A request pending here is taken in IDLE, i.e. once tx_busy reads 0.
                if (r_tx_cnt == TX_LAST) begin
                    w_tx_state = TX_IDLE;
                    w_tx_cnt   = '0;
                    w_txd      = 1'b1;
                    w_tx_busy  = 1'b0;
                end else begin
                    w_tx_cnt   = r_tx_cnt + CW'(1);
                end
            end
            default: begin
                w_tx_state = TX_IDLE;
                w_tx_cnt   = '0;
                w_tx_bit   = '0;
                w_txd      = 1'b1;
                w_tx_busy  = 1'b0;
            end
        endcase
    end

    // RX next state: r_rx_cnt counts edges since the last reference sample, so a
    // data/stop sample falls where it equals CLKS_PER_BIT.
    always_comb begin
        w_rx_state = r_rx_state;
        w_rx_cnt   = r_rx_cnt;
        w_rx_bit   = r_rx_bit;
        w_rx_shift = r_rx_shift;
        w_rx_data  = r_rx_data;
        w_rx_ready = 1'b0;
        w_rx_error = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (!bus.rxd) begin
                    w_rx_bit = '0;
                    w_rx_cnt = CW'(1);
                    // With a zero mid-point offset the detecting edge is itself the start check.
                    if (MID == 0) begin
                        w_rx_state = RX_DATA;
                    end else begin
                        w_rx_state = RX_START;
                    end
                end else begin
                    w_rx_state = RX_IDLE;
                end
            end
            RX_START: begin
                if (r_rx_cnt == RX_MID) begin
                    w_rx_cnt = CW'(1);
                    if (bus.rxd) begin
                        w_rx_state = RX_IDLE;
                    end else begin
                        w_rx_state = RX_DATA;
                    end
                end else begin
                    w_rx_cnt = r_rx_cnt + CW'(1);
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == RX_BIT) begin
                    w_rx_cnt   = CW'(1);
                    w_rx_shift = SIZE'({bus.rxd, r_rx_shift} >> 1);
                    if (r_rx_bit == LAST_BIT) begin
                        w_rx_state = RX_STOP;
                    end else begin
                        w_rx_bit   = r_rx_bit + BW'(1);
                    end
                end else begin
                    w_rx_cnt = r_rx_cnt + CW'(1);
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == RX_BIT) begin
                    w_rx_cnt = '0;
                    if (bus.rxd) begin
                        w_rx_data  = r_rx_shift;
                        w_rx_ready = 1'b1;
                        w_rx_state = RX_IDLE;
                    end else begin
                        w_rx_error = 1'b1;
                        w_rx_state = RX_WAIT_IDLE;
                    end
                end else begin
                    w_rx_cnt = r_rx_cnt + CW'(1);
                end
            end
            RX_WAIT_IDLE: begin
                // Stay off the line until it returns high, so a stuck-low rxd is not read as a new start.
                if (bus.rxd) begin
                    w_rx_state = RX_IDLE;
                end else begin
                    w_rx_state = RX_WAIT_IDLE;
                end
            end
            default: begin
                w_rx_state = RX_IDLE;
                w_rx_cnt   = '0;
                w_rx_bit   = '0;
            end
        endcase
    end

    // State and output registers for both directions.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_ready <= 1'b0;
            r_rx_error <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state;
            r_tx_cnt   <= w_tx_cnt;
            r_tx_bit   <= w_tx_bit;
            r_tx_shift <= w_tx_shift;
            r_txd      <= w_txd;
            r_tx_busy  <= w_tx_busy;
            r_rx_state <= w_rx_state;
            r_rx_cnt   <= w_rx_cnt;
            r_rx_bit   <= w_rx_bit;
            r_rx_shift <= w_rx_shift;
            r_rx_data  <= w_rx_data;
            r_rx_ready <= w_rx_ready;
            r_rx_error <= w_rx_error;
        end
    end

    assign bus.txd      = r_txd;
    assign bus.tx_busy  = r_tx_busy;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_ready = r_rx_ready;
    assign bus.rx_error = r_rx_error;

endmodule

// File: tb/tb_uart_tx_rx_pair.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_rx_pair
// Two instances: u_dut (CLKS_PER_BIT=1, txd looped to rxd unless the bench
// drives rxd itself) and u_dut16 (CLKS_PER_BIT=16, rxd driven by the bench).
// Words expected on rx_ready are queued when stimulus is applied and popped by
// per-instance monitors.
// ---------------------------------------------------------------------------
module tb_uart_tx_rx_pair;
    logic clk;
    logic rst_n;
    logic loop_en;
    logic rxd_drv;
    logic rxd16_drv;

    int checks = 0;
    int errors = 0;
    int rdy1 = 0, err1 = 0, rdy16 = 0, err16 = 0;
    logic [7:0] q1[$];
    logic [7:0] q16[$];

    uart_tx_rx_pair_if #(.SIZE(8)) if1 ();
    uart_tx_rx_pair_if #(.SIZE(8)) if16 ();

    assign if1.rxd  = loop_en ? if1.txd : rxd_drv;
    assign if16.rxd = rxd16_drv;

    uart_tx_rx_pair #(.SIZE(8), .CLKS_PER_BIT(1)) u_dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (if1)
    );

    uart_tx_rx_pair #(.SIZE(8), .CLKS_PER_BIT(16)) u_dut16 (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (if16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard for the CLKS_PER_BIT=1 instance.
    always @(negedge clk) begin
        logic [7:0] exp_w;
        if (if1.rx_ready || if1.rx_error) begin
            checks++;
            if (if1.rx_ready && if1.rx_error) begin
                errors++;
                $display("FAIL ready_error_exclusive actual=both required=one");
            end
        end
        if (if1.rx_error) err1++;
        if (if1.rx_ready) begin
            rdy1++;
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL sb1_unexpected actual=%02h required=no_word", if1.rx_data);
            end else begin
                exp_w = q1.pop_front();
                if (if1.rx_data !== exp_w) begin
                    errors++;
                    $display("FAIL sb1_data actual=%02h required=%02h", if1.rx_data, exp_w);
                end
            end
        end
    end

    // Scoreboard for the CLKS_PER_BIT=16 instance.
    always @(negedge clk) begin
        logic [7:0] exp_w;
        if (if16.rx_error) err16++;
        if (if16.rx_ready) begin
            rdy16++;
            checks++;
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL sb16_unexpected actual=%02h required=no_word", if16.rx_data);
            end else begin
                exp_w = q16.pop_front();
                if (if16.rx_data !== exp_w) begin
                    errors++;
                    $display("FAIL sb16_data actual=%02h required=%02h", if16.rx_data, exp_w);
                end
            end
        end
    end

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        if1.tx_data = d;
        if1.tx_rq   = 1'b1;
        q1.push_back(d);
    endtask

    task automatic drain1(input string name);
        for (int i = 0; i < 400; i++) begin
            if (q1.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout actual=%0d_pending required=0", name, q1.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (50) @(negedge clk);
        checks++;
        if ({if1.txd, if1.tx_busy, if1.rx_ready, if1.rx_error} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl actual=%b required=1000",
                     {if1.txd, if1.tx_busy, if1.rx_ready, if1.rx_error});
        end
        checks++;
        if (if1.rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx_data actual=%02h required=00", if1.rx_data);
        end
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
    endtask

    task automatic test_loopback();
        logic [9:0] frame = {1'b1, 8'hA5, 1'b0};
        int busy_n = 0;
        int rdy_at = -1;
        int r0 = rdy1;
        int e0 = err1;
        start_tx(8'hA5);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) if1.tx_rq = 1'b0;
            if (i < 10) begin
                checks++;
                if (if1.txd !== frame[i]) begin
                    errors++;
                    $display("FAIL loop_txd_bit%0d actual=%b required=%b", i, if1.txd, frame[i]);
                end
            end
            if (if1.tx_busy) busy_n++;
            if (if1.rx_ready && rdy_at < 0) rdy_at = i;
        end
        checks++;
        if (busy_n != 10) begin
            errors++;
            $display("FAIL loop_busy_len actual=%0d required=10", busy_n);
        end
        checks++;
        if (rdy_at != 10) begin
            errors++;
            $display("FAIL loop_ready_latency actual=%0d required=10", rdy_at);
        end
        drain1("loop");
        checks++;
        if (rdy1 - r0 != 1 || err1 != e0) begin
            errors++;
            $display("FAIL loop_pulses actual=rdy%0d_err%0d required=rdy1_err0", rdy1 - r0, err1 - e0);
        end
    endtask

    task automatic test_back_to_back();
        int rises = 0, high = 0, gap = 0;
        int r0 = rdy1;
        logic prev = 1'b0;
        start_tx(8'h00);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if1.tx_busy && !prev) begin
                rises++;
                if (rises == 1) begin
                    if1.tx_data = 8'hFF;
                    q1.push_back(8'hFF);
                end else begin
                    if1.tx_rq = 1'b0;
                end
            end
            if (if1.tx_busy) high++;
            if (!if1.tx_busy && rises == 1) gap++;
            prev = if1.tx_busy;
        end
        checks++;
        if (rises != 2 || high != 20) begin
            errors++;
            $display("FAIL b2b_frames actual=rises%0d_high%0d required=rises2_high20", rises, high);
        end
        checks++;
        if (gap != 1) begin
            errors++;
            $display("FAIL b2b_gap actual=%0d required=1", gap);
        end
        drain1("b2b");
        checks++;
        if (rdy1 - r0 != 2) begin
            errors++;
            $display("FAIL b2b_ready_count actual=%0d required=2", rdy1 - r0);
        end
    endtask

    task automatic test_ignore_midframe();
        int rises = 0, high = 0;
        int r0 = rdy1;
        logic prev = 1'b0;
        start_tx(8'h96);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0) if1.tx_rq = 1'b0;
            if (i == 4) begin
                if1.tx_data = 8'h3C;
                if1.tx_rq   = 1'b1;
            end
            if (i == 5) if1.tx_rq = 1'b0;
            if (if1.tx_busy && !prev) rises++;
            if (if1.tx_busy) high++;
            prev = if1.tx_busy;
        end
        checks++;
        if (rises != 1 || high != 10) begin
            errors++;
            $display("FAIL ignore_busy actual=rises%0d_high%0d required=rises1_high10", rises, high);
        end
        drain1("ignore");
        repeat (20) @(negedge clk);
        checks++;
        if (rdy1 - r0 != 1) begin
            errors++;
            $display("FAIL ignore_ready_count actual=%0d required=1", rdy1 - r0);
        end
    endtask

    task automatic drive_rx1(input logic [7:0] d, input logic stop);
        logic [9:0] frame = {stop, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rxd_drv = frame[k];
        end
    endtask

    task automatic test_frame_error();
        int r0 = rdy1;
        int e0 = err1;
        rxd_drv = 1'b1;
        loop_en = 1'b0;
        repeat (3) @(negedge clk);
        drive_rx1(8'h5A, 1'b0);
        repeat (12) begin
            @(negedge clk);
            rxd_drv = 1'b0;
        end
        checks++;
        if (err1 - e0 != 1 || rdy1 != r0) begin
            errors++;
            $display("FAIL ferr_pulses actual=err%0d_rdy%0d required=err1_rdy0", err1 - e0, rdy1 - r0);
        end
        checks++;
        if (if1.rx_data !== 8'h96) begin
            errors++;
            $display("FAIL ferr_rx_data_hold actual=%02h required=96", if1.rx_data);
        end
        @(negedge clk);
        rxd_drv = 1'b1;
        repeat (2) @(negedge clk);
        q1.push_back(8'h11);
        drive_rx1(8'h11, 1'b1);
        repeat (3) @(negedge clk);
        drain1("ferr_rearm");
        checks++;
        if (rdy1 - r0 != 1 || err1 - e0 != 1) begin
            errors++;
            $display("FAIL ferr_rearm actual=rdy%0d_err%0d required=rdy1_err1", rdy1 - r0, err1 - e0);
        end
        loop_en = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        int r0;
        @(negedge clk);
        if1.tx_data = 8'h77;
        if1.tx_rq   = 1'b1;
        @(negedge clk);
        if1.tx_rq = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({if1.txd, if1.tx_busy, if1.rx_ready, if1.rx_error} !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_ctrl actual=%b required=1000",
                     {if1.txd, if1.tx_busy, if1.rx_ready, if1.rx_error});
        end
        checks++;
        if (if1.rx_data !== 8'h00) begin
            errors++;
            $display("FAIL midrst_rx_data actual=%02h required=00", if1.rx_data);
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        r0 = rdy1;
        start_tx(8'hC3);
        @(negedge clk);
        if1.tx_rq = 1'b0;
        drain1("midrst");
        checks++;
        if (rdy1 - r0 != 1 || if1.rx_data !== 8'hC3) begin
            errors++;
            $display("FAIL midrst_next_word actual=rdy%0d_%02h required=rdy1_c3", rdy1 - r0, if1.rx_data);
        end
    endtask

    task automatic test_cpb16();
        logic [9:0] frame = {1'b1, 8'h81, 1'b0};
        int r0 = rdy16;
        int e0 = err16;
        rxd16_drv = 1'b1;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rxd16_drv = 1'b0;
        end
        @(negedge clk);
        rxd16_drv = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (rdy16 != r0 || err16 != e0) begin
            errors++;
            $display("FAIL cpb16_glitch actual=rdy%0d_err%0d required=rdy0_err0", rdy16 - r0, err16 - e0);
        end
        q16.push_back(8'h81);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rxd16_drv = frame[k];
            repeat (15) @(negedge clk);
        end
        for (int i = 0; i < 100; i++) begin
            if (q16.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (q16.size() != 0) begin
            errors++;
            $display("FAIL cpb16_timeout actual=%0d_pending required=0", q16.size());
        end
        checks++;
        if (rdy16 - r0 != 1 || err16 != e0 || if16.rx_data !== 8'h81) begin
            errors++;
            $display("FAIL cpb16_frame actual=rdy%0d_err%0d_%02h required=rdy1_err0_81",
                     rdy16 - r0, err16 - e0, if16.rx_data);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        loop_en      = 1'b1;
        rxd_drv      = 1'b1;
        rxd16_drv    = 1'b1;
        if1.tx_data  = 8'h00;
        if1.tx_rq    = 1'b0;
        if16.tx_data = 8'h00;
        if16.tx_rq   = 1'b0;
        test_reset();
        test_loopback();
        test_back_to_back();
        test_ignore_midframe();
        test_frame_error();
        test_reset_midframe();
        test_cpb16();
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
